// File: rtl/alu_iter.sv
// Multi-cycle integer ALU with valid/ready handshakes and a bit-serial shifter.
// Define ALU_BARREL_SHIFT_EN to compute shifts combinationally in one cycle instead.
module alu_iter #(
    parameter  int WIDTH = 32,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [3:0]       i_ctrl,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             ready_q, ready_d;
`ifndef ALU_BARREL_SHIFT_EN
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [1:0]       kind_q, kind_d;
    logic             is_shift;
    logic [SHW-1:0]   shamt;
`endif

    function automatic logic [WIDTH-1:0] alu_op(input logic [3:0] c,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        logic [SHW-1:0]   sh;
        logic [WIDTH-1:0] r;
        sh = b[SHW-1:0];
        case (c)
            4'd0:    r = a & b;
            4'd1:    r = a | b;
            4'd2:    r = a ^ b;
            4'd3:    r = ~(a & b);
            4'd4:    r = ~(a | b);
            4'd5:    r = a + b;
            4'd6:    r = a - b;
            4'd7:    r = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            4'd8:    r = {{(WIDTH-1){1'b0}}, (a < b)};
            4'd9:    r = a << sh;
            4'd10:   r = a >> sh;
            4'd11:   r = $signed(a) >>> sh;
            default: r = '0;
        endcase
        return r;
    endfunction

`ifndef ALU_BARREL_SHIFT_EN
    // kind is i_ctrl[1:0] of a shift code: 01 SLL, 10 SRL, 11 SRA
    function automatic logic [WIDTH-1:0] shift_one(input logic [1:0] kind,
                                                   input logic [WIDTH-1:0] r);
        logic [WIDTH-1:0] s;
        case (kind)
            2'b01:   s = {r[WIDTH-2:0], 1'b0};
            2'b10:   s = {1'b0, r[WIDTH-1:1]};
            2'b11:   s = {r[WIDTH-1], r[WIDTH-1:1]};
            default: s = r;
        endcase
        return s;
    endfunction

    assign is_shift = (i_ctrl == 4'd9) || (i_ctrl == 4'd10) || (i_ctrl == 4'd11);
    assign shamt    = i_b[SHW-1:0];
`endif

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        valid_d  = valid_q;
        ready_d  = ready_q;
`ifndef ALU_BARREL_SHIFT_EN
        cnt_d    = cnt_q;
        kind_d   = kind_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    ready_d = 1'b0;
`ifndef ALU_BARREL_SHIFT_EN
                    if (is_shift && (shamt != '0)) begin
                        result_d = i_a;
                        cnt_d    = shamt;
                        kind_d   = i_ctrl[1:0];
                        state_d  = SHIFT;
                    end else begin
                        result_d = alu_op(i_ctrl, i_a, i_b);
                        valid_d  = 1'b1;
                        state_d  = DONE;
                    end
`else
                    result_d = alu_op(i_ctrl, i_a, i_b);
                    valid_d  = 1'b1;
                    state_d  = DONE;
`endif
                end
            end
`ifndef ALU_BARREL_SHIFT_EN
            SHIFT: begin
                result_d = shift_one(kind_q, result_q);
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == SHW'(1)) begin
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
`endif
            DONE: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    ready_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                valid_d = 1'b0;
                ready_d = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            valid_q  <= 1'b0;
            ready_q  <= 1'b1;
`ifndef ALU_BARREL_SHIFT_EN
            cnt_q    <= '0;
            kind_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            valid_q  <= valid_d;
            ready_q  <= ready_d;
`ifndef ALU_BARREL_SHIFT_EN
            cnt_q    <= cnt_d;
            kind_q   <= kind_d;
`endif
        end
    end

    assign o_ready  = ready_q;
    assign o_valid  = valid_q;
    assign o_result = result_q;
    assign o_zero   = (result_q == '0);

endmodule

// File: tb/tb_alu_iter.sv
// Self-checking bench for alu_iter: directed cases from hand-worked values plus a
// randomized run compared every cycle against a latency/result model of the ALU.
module tb_alu_iter;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [3:0]  i_ctrl;
    logic [31:0] i_a;
    logic [31:0] i_b;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_zero;

    int nCompared;
    int nMismatched;

    alu_iter #(.WIDTH(32)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_ctrl   (i_ctrl),
        .i_a      (i_a),
        .i_b      (i_b),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_zero   (o_zero)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference result straight from the operation table, using plain arithmetic
    function automatic logic [31:0] refAlu(input logic [3:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        int unsigned sh;
        logic [31:0] fill;
        sh = b % 32;
        case (c)
            4'd0:  return a & b;
            4'd1:  return a | b;
            4'd2:  return a ^ b;
            4'd3:  return ~(a & b);
            4'd4:  return ~(a | b);
            4'd5:  return a + b;
            4'd6:  return a + (~b) + 32'd1;
            4'd7:  return ((a ^ 32'h8000_0000) < (b ^ 32'h8000_0000)) ? 32'd1 : 32'd0;
            4'd8:  return (a < b) ? 32'd1 : 32'd0;
            4'd9:  return a * (32'd1 << sh);
            4'd10: return a / (32'd1 << sh);
            4'd11: begin
                fill = a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0;
                return (a / (32'd1 << sh)) | fill;
            end
            default: return 32'd0;
        endcase
    endfunction

    // Cycles from accept edge to first o_valid cycle
    function automatic int refLatency(input logic [3:0] c, input logic [31:0] b);
`ifdef ALU_BARREL_SHIFT_EN
        return 1;
`else
        if ((c >= 4'd9) && (c <= 4'd11) && ((b % 32) != 0))
            return int'(b % 32) + 1;
        return 1;
`endif
    endfunction

    // Shared comparator: every check in the bench goes through here
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual,
                     expected, $time);
        end
    endtask

    // Model: pending countdown until result appears, then held until consumed
    logic [31:0] mResult;
    logic        mValid;
    int          mWait;
    logic        expReady;

    assign expReady = !mValid && (mWait == 0);

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mValid  <= 1'b0;
            mWait   <= 0;
            mResult <= 32'd0;
        end else if (mValid) begin
            if (i_ready) mValid <= 1'b0;
        end else if (mWait > 0) begin
            mWait <= mWait - 1;
            if (mWait == 1) mValid <= 1'b1;
        end else if (i_valid) begin
            mResult <= refAlu(i_ctrl, i_a, i_b);
            if (refLatency(i_ctrl, i_b) == 1) mValid <= 1'b1;
            else mWait <= refLatency(i_ctrl, i_b) - 1;
        end
    end

    // Continuous compare on the falling edge, away from the active edge
    initial begin
        forever begin
            @(negedge i_clk);
            checkOutput("ready", {31'd0, o_ready}, {31'd0, expReady});
            checkOutput("valid", {31'd0, o_valid}, {31'd0, mValid});
            if (mValid) begin
                checkOutput("result", o_result, mResult);
                checkOutput("zero", {31'd0, o_zero}, {31'd0, (mResult == 32'd0)});
            end
            if (!i_rst_n) checkOutput("reset_result", o_result, 32'd0);
        end
    end

    // Present one request for a single cycle; called at #1 after a rising edge
    task automatic applyStimulus(input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b);
        i_valid = 1'b1;
        i_ctrl  = c;
        i_a     = a;
        i_b     = b;
        @(posedge i_clk); #1;
        i_valid = 1'b0;
        i_a     = $urandom;
        i_b     = $urandom;
    endtask

    // Run one op, check latency/result, optionally stall, then consume it
    task automatic runOp(input string name, input logic [3:0] c, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] expected,
                         input int expLat, input int holdCycles);
        int lat;
        applyStimulus(c, a, b);
        lat = 1;
        while (!o_valid && lat < 64) begin
            @(posedge i_clk); #1;
            lat++;
        end
        checkOutput({name, "_lat"}, lat, expLat);
        checkOutput({name, "_res"}, o_result, expected);
        checkOutput({name, "_zero"}, {31'd0, o_zero}, {31'd0, (expected == 32'd0)});
        for (int h = 0; h < holdCycles; h++) begin
            i_valid = 1'b1;
            i_ctrl  = 4'(h + 5);
            @(posedge i_clk); #1;
            checkOutput({name, "_hold_res"}, o_result, expected);
            checkOutput({name, "_hold_ready"}, {31'd0, o_ready}, 32'd0);
            checkOutput({name, "_hold_valid"}, {31'd0, o_valid}, 32'd1);
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        checkOutput({name, "_idle_ready"}, {31'd0, o_ready}, 32'd1);
        checkOutput({name, "_idle_valid"}, {31'd0, o_valid}, 32'd0);
    endtask

    int serial;

    initial begin
        nCompared   = 0;
        nMismatched = 0;
`ifdef ALU_BARREL_SHIFT_EN
        serial = 0;
`else
        serial = 1;
`endif
        i_rst_n = 1'b0;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_ctrl  = 4'd0;
        i_a     = 32'd0;
        i_b     = 32'd0;

        // Pin the reference model to hand-worked values
        checkOutput("model_add", refAlu(4'd5, 32'hFFFF_FFFF, 32'd1), 32'd0);
        checkOutput("model_sub", refAlu(4'd6, 32'd5, 32'd7), 32'hFFFF_FFFE);
        checkOutput("model_slt", refAlu(4'd7, 32'hFFFF_FFFF, 32'd1), 32'd1);
        checkOutput("model_sltu", refAlu(4'd8, 32'hFFFF_FFFF, 32'd1), 32'd0);
        checkOutput("model_sra", refAlu(4'd11, 32'h8000_0000, 32'd4), 32'hF800_0000);
        checkOutput("model_sll", refAlu(4'd9, 32'd1, 32'h25), 32'h20);
        checkOutput("model_nor", refAlu(4'd4, 32'hF0F0_0000, 32'h0F0F_0000), 32'h0000_FFFF);

        repeat (2) @(posedge i_clk);
        #1;
        checkOutput("rst_ready", {31'd0, o_ready}, 32'd1);
        checkOutput("rst_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("rst_result", o_result, 32'd0);
        checkOutput("rst_zero", {31'd0, o_zero}, 32'd1);
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Directed cases with literal expectations
        runOp("add", 4'd5, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
        runOp("sub", 4'd6, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 0);
        runOp("slt", 4'd7, 32'hFFFF_FFFF, 32'd1, 32'd1, 1, 0);
        runOp("sltu", 4'd8, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 0);
        runOp("code_c", 4'hC, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0, 1, 0);
        runOp("sra4", 4'd11, 32'h8000_0000, 32'd4, 32'hF800_0000, serial ? 5 : 1, 0);
        runOp("sll5", 4'd9, 32'd1, 32'h25, 32'h20, serial ? 6 : 1, 0);
        runOp("bp_xor", 4'd2, 32'hA5A5_0000, 32'h0000_5A5A, 32'hA5A5_5A5A, 1, 3);
        runOp("srl31", 4'd10, 32'hFFFF_FFFF, 32'd31, 32'd1, serial ? 32 : 1, 0);
        runOp("sh0", 4'd9, 32'hCAFE_1234, 32'h0000_0020, 32'hCAFE_1234, 1, 0);

        // Reset three cycles into a shift by 10
        applyStimulus(4'd10, 32'hDEAD_BEEF, 32'd10);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", {31'd0, o_valid}, 32'd0);
        checkOutput("midrst_result", o_result, 32'd0);
        checkOutput("midrst_ready", {31'd0, o_ready}, 32'd1);
        checkOutput("midrst_zero", {31'd0, o_zero}, 32'd1);
        @(posedge i_clk); #1;
        i_rst_n = 1'b1;
        repeat (12) begin
            @(posedge i_clk); #1;
            checkOutput("postrst_valid", {31'd0, o_valid}, 32'd0);
        end
        runOp("add_after_rst", 4'd5, 32'd100, 32'd23, 32'd123, 1, 0);

        // Randomized traffic, checked every cycle by the compare process
        for (int n = 0; n < 4000; n++) begin
            @(posedge i_clk); #1;
            i_valid = ($urandom % 2) == 0;
            i_ctrl  = ($urandom % 3 == 0) ? 4'(9 + $urandom % 3) : 4'($urandom % 16);
            i_a     = ($urandom % 4 == 0) ? 32'h8000_0000 | $urandom : $urandom;
            i_b     = ($urandom % 4 == 0) ? ($urandom % 32) : $urandom;
            if ($urandom % 8 == 0) i_a = i_b;
            i_ready = ($urandom % 3) != 0;
        end
        i_valid = 1'b0;
        i_ready = 1'b1;
        repeat (40) @(posedge i_clk);
        #1;
        checkOutput("drain_ready", {31'd0, o_ready}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
